multicycle_ctrl: RTL and testbench

- Multi-cycle CPU control unit: a Moore/Mealy FSM that sequences one instruction through fetch, decode, execute, memory and write-back.
- Generates every datapath strobe: PC write, IR write, register-file write enable and destination select, ALU operand/op selects, data-memory read/write, PC source.
- Sits between the instruction register and the datapath. It is the only driver of the register file's write enable and write-register select.

---
 rtl/multicycle_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multi-cycle CPU control FSM sequencing IF/ID/EXE/MEM/WB and
//            driving every datapath strobe and select.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int OPW = 6,
  parameter int STW = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           PCWre,
  output logic           IRWre,
  output logic           RegWre,
  output logic [1:0]     RegDst,
  output logic           WrRegDSrc,
  output logic           ALUSrcA,
  output logic           ALUSrcB,
  output logic           ExtSel,
  output logic [2:0]     ALUOp,
  output logic           mRD,
  output logic           mWR,
  output logic           DBDataSrc,
  output logic [1:0]     PCSrc,
  output logic [STW-1:0] state
);

  typedef enum logic [STW-1:0] {
    sIF     = 3'b000,
    sID     = 3'b001,
    sEXE_LS = 3'b010,
    sMEM    = 3'b011,
    sWB_LD  = 3'b100,
    sEXE_BR = 3'b101,
    sEXE_AL = 3'b110,
    sWB_AL  = 3'b111
  } stateT;

  localparam logic [OPW-1:0] c_ADD   = 6'b000000;
  localparam logic [OPW-1:0] c_SUB   = 6'b000001;
  localparam logic [OPW-1:0] c_ADDIU = 6'b000010;
  localparam logic [OPW-1:0] c_AND   = 6'b010000;
  localparam logic [OPW-1:0] c_ANDI  = 6'b010001;
  localparam logic [OPW-1:0] c_ORI   = 6'b010010;
  localparam logic [OPW-1:0] c_SLL   = 6'b011000;
  localparam logic [OPW-1:0] c_SLTI  = 6'b011100;
  localparam logic [OPW-1:0] c_SW    = 6'b100110;
  localparam logic [OPW-1:0] c_LW    = 6'b100111;
  localparam logic [OPW-1:0] c_BEQ   = 6'b110100;
  localparam logic [OPW-1:0] c_BNE   = 6'b110101;
  localparam logic [OPW-1:0] c_J     = 6'b111000;
  localparam logic [OPW-1:0] c_JR    = 6'b111001;
  localparam logic [OPW-1:0] c_JAL   = 6'b111010;
  localparam logic [OPW-1:0] c_HALT  = 6'b111111;

  stateT r_state;
  stateT w_nextState;

  logic w_isRtype, w_isImm, w_isAlu, w_isLW, w_isSW, w_isBEQ, w_isBNE;
  logic w_isJAL, w_isJR, w_isHalt;
  logic [2:0] w_aluOp;

  assign w_isRtype = (opcode == c_ADD) | (opcode == c_SUB) |
                     (opcode == c_AND) | (opcode == c_SLL);
  assign w_isImm   = (opcode == c_ADDIU) | (opcode == c_ANDI) |
                     (opcode == c_ORI)   | (opcode == c_SLTI);
  assign w_isAlu   = w_isRtype | w_isImm;
  assign w_isLW    = (opcode == c_LW);
  assign w_isSW    = (opcode == c_SW);
  assign w_isBEQ   = (opcode == c_BEQ);
  assign w_isBNE   = (opcode == c_BNE);
  assign w_isJAL   = (opcode == c_JAL);
  assign w_isJR    = (opcode == c_JR);
  assign w_isHalt  = (opcode == c_HALT);

  always_comb begin
    w_aluOp = 3'b000;
    case (opcode)
      c_SUB, c_BEQ, c_BNE: w_aluOp = 3'b001;
      c_SLL:               w_aluOp = 3'b010;
      c_ORI:               w_aluOp = 3'b011;
      c_AND, c_ANDI:       w_aluOp = 3'b100;
      c_SLTI:              w_aluOp = 3'b101;
      default:             w_aluOp = 3'b000;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= sIF;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    PCWre       = 1'b0;
    IRWre       = 1'b0;
    RegWre      = 1'b0;
    RegDst      = 2'b00;
    WrRegDSrc   = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 1'b0;
    ExtSel      = 1'b0;
    ALUOp       = 3'b000;
    mRD         = 1'b0;
    mWR         = 1'b0;
    DBDataSrc   = 1'b0;
    PCSrc       = 2'b00;

    // Operand selects are held from execute through write-back
    if (r_state != sIF && r_state != sID) begin
      ALUOp   = w_aluOp;
      ALUSrcA = (opcode == c_SLL);
      ALUSrcB = w_isImm | w_isLW | w_isSW;
      ExtSel  = (opcode == c_ADDIU) | (opcode == c_SLTI) | w_isLW | w_isSW |
                w_isBEQ | w_isBNE;
    end

    case (r_state)
      sIF: begin
        IRWre       = 1'b1;
        w_nextState = sID;
      end
      sID: begin
        if (w_isHalt) begin
          w_nextState = sID;
        end else if (w_isBEQ | w_isBNE) begin
          w_nextState = sEXE_BR;
        end else if (w_isLW | w_isSW) begin
          w_nextState = sEXE_LS;
        end else if (w_isAlu) begin
          w_nextState = sEXE_AL;
        end else begin
          // J/JR/JAL/NOP complete here
          w_nextState = sIF;
          PCWre       = 1'b1;
          if (w_isJAL) begin
            RegWre = 1'b1;
            PCSrc  = 2'b11;
          end else if (opcode == c_J) begin
            PCSrc = 2'b11;
          end else if (w_isJR) begin
            PCSrc = 2'b10;
          end
        end
      end
      sEXE_AL: w_nextState = sWB_AL;
      sWB_AL: begin
        w_nextState = sIF;
        PCWre       = 1'b1;
        RegWre      = 1'b1;
        RegDst      = w_isRtype ? 2'b10 : 2'b01;
        WrRegDSrc   = 1'b1;
      end
      sEXE_LS: w_nextState = sMEM;
      sMEM: begin
        if (w_isLW) begin
          w_nextState = sWB_LD;
          mRD         = 1'b1;
        end else begin
          w_nextState = sIF;
          PCWre       = 1'b1;
          mWR         = w_isSW;
        end
      end
      sWB_LD: begin
        w_nextState = sIF;
        PCWre       = 1'b1;
        RegWre      = 1'b1;
        RegDst      = 2'b01;
        WrRegDSrc   = 1'b1;
        DBDataSrc   = 1'b1;
      end
      sEXE_BR: begin
        w_nextState = sIF;
        PCWre       = 1'b1;
        PCSrc       = ((w_isBEQ & zero) | (w_isBNE & ~zero)) ? 2'b01 : 2'b00;
      end
      default: w_nextState = sIF;
    endcase

    // Write enables are suppressed for the whole reset window
    if (!RST) begin
      PCWre  = 1'b0;
      IRWre  = 1'b0;
      RegWre = 1'b0;
      mRD    = 1'b0;
      mWR    = 1'b0;
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Directed self-checking bench for multicycle_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] opcode;
  logic       zero;
  logic       PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel;
  logic       mRD, mWR, DBDataSrc;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp, state;

  int nAssert = 0;
  int nFail   = 0;

  multicycle_ctrl #(.OPW(6), .STW(3)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
    .DBDataSrc(DBDataSrc), .PCSrc(PCSrc), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Enable vector order: {PCWre, IRWre, RegWre, mRD, mWR}
  task automatic chkSt(input string tag, input logic [2:0] s, input logic [4:0] en);
    chk({tag, ".state"}, {5'b0, state}, {5'b0, s});
    chk({tag, ".en"}, {3'b0, PCWre, IRWre, RegWre, mRD, mWR}, {3'b0, en});
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  logic [5:0] brOp [4] = '{6'b110100, 6'b110100, 6'b110101, 6'b110101};
  logic       brZ  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0] brPc [4] = '{2'b01, 2'b00, 2'b00, 2'b01};

  initial begin
    RST    = 1'b0;
    opcode = 6'b000000;
    zero   = 1'b0;
    #2;
    chkSt("reset", 3'b000, 5'b00000);
    #10;
    RST = 1'b1;
    #1;
    chkSt("add.if", 3'b000, 5'b01000);

    // ADD
    tick; chkSt("add.id", 3'b001, 5'b00000);
    tick; chkSt("add.exe", 3'b110, 5'b00000);
    chk("add.exe.aluop", {5'b0, ALUOp}, 8'd0);
    tick; chkSt("add.wb", 3'b111, 5'b10100);
    chk("add.wb.regdst", {6'b0, RegDst}, 8'b10);
    chk("add.wb.wrsrc", {7'b0, WrRegDSrc}, 8'd1);
    chk("add.wb.aluop", {5'b0, ALUOp}, 8'd0);
    tick; chkSt("add.done", 3'b000, 5'b01000);

    // LW
    opcode = 6'b100111;
    tick; chkSt("lw.id", 3'b001, 5'b00000);
    tick; chkSt("lw.exe", 3'b010, 5'b00000);
    chk("lw.exe.srcb", {7'b0, ALUSrcB}, 8'd1);
    chk("lw.exe.ext", {7'b0, ExtSel}, 8'd1);
    tick; chkSt("lw.mem", 3'b011, 5'b00010);
    tick; chkSt("lw.wb", 3'b100, 5'b10100);
    chk("lw.wb.dbsrc", {7'b0, DBDataSrc}, 8'd1);
    chk("lw.wb.regdst", {6'b0, RegDst}, 8'b01);
    tick; chkSt("lw.done", 3'b000, 5'b01000);

    // SW
    opcode = 6'b100110;
    tick; chkSt("sw.id", 3'b001, 5'b00000);
    tick; chkSt("sw.exe", 3'b010, 5'b00000);
    tick; chkSt("sw.mem", 3'b011, 5'b10001);
    tick; chkSt("sw.done", 3'b000, 5'b01000);

    // SLL and ORI operand selects
    opcode = 6'b011000;
    tick; tick; chkSt("sll.exe", 3'b110, 5'b00000);
    chk("sll.srca", {7'b0, ALUSrcA}, 8'd1);
    chk("sll.aluop", {5'b0, ALUOp}, 8'b010);
    tick; tick;
    opcode = 6'b010010;
    tick; tick;
    chk("ori.aluop", {5'b0, ALUOp}, 8'b011);
    chk("ori.ext", {7'b0, ExtSel}, 8'd0);
    chk("ori.srcb", {7'b0, ALUSrcB}, 8'd1);
    tick; chk("ori.wb.regdst", {6'b0, RegDst}, 8'b01);
    tick; chkSt("ori.done", 3'b000, 5'b01000);

    // BEQ/BNE with both zero values
    for (int i = 0; i < 4; i++) begin
      opcode = brOp[i];
      zero   = brZ[i];
      tick; chkSt("br.id", 3'b001, 5'b00000);
      tick; chkSt("br.exe", 3'b101, 5'b10000);
      chk($sformatf("br%0d.pcsrc", i), {6'b0, PCSrc}, {6'b0, brPc[i]});
      tick; chkSt("br.done", 3'b000, 5'b01000);
    end
    zero = 1'b0;

    // JAL
    opcode = 6'b111010;
    tick; chkSt("jal.id", 3'b001, 5'b10100);
    chk("jal.regdst", {6'b0, RegDst}, 8'b00);
    chk("jal.wrsrc", {7'b0, WrRegDSrc}, 8'd0);
    chk("jal.pcsrc", {6'b0, PCSrc}, 8'b11);
    tick; chkSt("jal.done", 3'b000, 5'b01000);

    // JR
    opcode = 6'b111001;
    tick; chkSt("jr.id", 3'b001, 5'b10000);
    chk("jr.pcsrc", {6'b0, PCSrc}, 8'b10);
    tick; chkSt("jr.done", 3'b000, 5'b01000);

    // HALT holds until asynchronous reset
    opcode = 6'b111111;
    tick;
    for (int i = 0; i < 20; i++) begin
      chkSt("halt.hold", 3'b001, 5'b00000);
      tick;
    end
    #2 RST = 1'b0;
    #1 chkSt("halt.rst", 3'b000, 5'b00000);
    #1 RST = 1'b1;
    tick; chkSt("halt.after", 3'b001, 5'b00000);

    // Reset landing inside sWB_AL
    #1 RST = 1'b0;
    #1 RST = 1'b1;
    opcode = 6'b000000;
    #1 chkSt("mid.if", 3'b000, 5'b01000);
    tick; tick; tick; chkSt("mid.wb", 3'b111, 5'b10100);
    #1 RST = 1'b0;
    #1 chkSt("mid.rst", 3'b000, 5'b00000);
    chk("mid.regwre", {7'b0, RegWre}, 8'd0);
    #1 RST = 1'b1;
    #1 chkSt("mid.rel", 3'b000, 5'b01000);

    // Undefined opcode behaves as NOP
    opcode = 6'b101010;
    tick; chkSt("nop.id", 3'b001, 5'b10000);
    chk("nop.pcsrc", {6'b0, PCSrc}, 8'b00);
    tick; chkSt("nop.done", 3'b000, 5'b01000);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
